// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg: shared ALU shift types, opcodes and widths.
// Used by shift_pipe and shift_stage (SHIFT_PIPE_ROR_EN selects rotate build).
package shift_pipe_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t SHIFT_OP_SLL = 2'b00;
  localparam shift_op_t SHIFT_OP_SRA = 2'b01;
  localparam shift_op_t SHIFT_OP_SRL = 2'b10;
  localparam shift_op_t SHIFT_OP_ROR = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_st_t;

  function automatic logic [WIDTH-1:0] bit_rev(
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = d[WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage: one power-of-two left-shift step of the barrel shifter.
// Low bits are filled with i_fill, or with the wrapped top bits when i_rot.
module shift_stage
  import shift_pipe_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  logic             i_fill,
  input  logic             i_rot,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_low;

  assign w_shl = {i_data[WIDTH-1-DIST:0], {DIST{1'b0}}};

  assign w_low = i_rot
    ? {{(WIDTH-DIST){1'b0}}, i_data[WIDTH-1:WIDTH-DIST]}
    : {{(WIDTH-DIST){1'b0}}, {DIST{i_fill}}};

  assign o_data = i_en ? (w_shl | w_low) : i_data;

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage pipelined barrel shifter with valid/ready on both sides.
// Define SHIFT_PIPE_ROR_EN to make op 11 rotate right; otherwise op 11 is SRL.
module shift_pipe
  import shift_pipe_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_op_t          op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result
);

  stage_st_t        r_s1_st;
  stage_st_t        r_s2_st;
  stage_st_t        w_s1_nxt;
  stage_st_t        w_s2_nxt;

  logic [WIDTH-1:0] r_s1_data;
  logic [1:0]       r_s1_shamt;
  shift_op_t        r_s1_op;
  logic             r_s1_fill;
  logic [WIDTH-1:0] r_result;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_s1_right;
  logic             w_s1_fill;
  logic             w_s1_rot;
  logic             w_s2_right;
  logic             w_s2_rot;
  logic [WIDTH-1:0] w_s1_in;
  logic [WIDTH-1:0] w_d16;
  logic [WIDTH-1:0] w_d8;
  logic [WIDTH-1:0] w_d4;
  logic [WIDTH-1:0] w_d2;
  logic [WIDTH-1:0] w_d1;
  logic [WIDTH-1:0] w_s2_res;

  // Right-type ops run through the left-only datapath on reversed bits.
  assign w_s1_right = (op != SHIFT_OP_SLL);
  assign w_s1_fill  = (op == SHIFT_OP_SRA) & operand[WIDTH-1];
  assign w_s2_right = (r_s1_op != SHIFT_OP_SLL);

`ifdef SHIFT_PIPE_ROR_EN
  assign w_s1_rot = (op == SHIFT_OP_ROR);
  assign w_s2_rot = (r_s1_op == SHIFT_OP_ROR);
`else
  assign w_s1_rot = 1'b0;
  assign w_s2_rot = 1'b0;
`endif

  assign w_s1_in = w_s1_right ? bit_rev(operand) : operand;

  shift_stage #(.DIST(16)) u_st16 (
    .i_data (w_s1_in),
    .i_en   (shamt[4]),
    .i_fill (w_s1_fill),
    .i_rot  (w_s1_rot),
    .o_data (w_d16)
  );

  shift_stage #(.DIST(8)) u_st8 (
    .i_data (w_d16),
    .i_en   (shamt[3]),
    .i_fill (w_s1_fill),
    .i_rot  (w_s1_rot),
    .o_data (w_d8)
  );

  shift_stage #(.DIST(4)) u_st4 (
    .i_data (w_d8),
    .i_en   (shamt[2]),
    .i_fill (w_s1_fill),
    .i_rot  (w_s1_rot),
    .o_data (w_d4)
  );

  shift_stage #(.DIST(2)) u_st2 (
    .i_data (r_s1_data),
    .i_en   (r_s1_shamt[1]),
    .i_fill (r_s1_fill),
    .i_rot  (w_s2_rot),
    .o_data (w_d2)
  );

  shift_stage #(.DIST(1)) u_st1 (
    .i_data (w_d2),
    .i_en   (r_s1_shamt[0]),
    .i_fill (r_s1_fill),
    .i_rot  (w_s2_rot),
    .o_data (w_d1)
  );

  assign w_s2_res = w_s2_right ? bit_rev(w_d1) : w_d1;

  // No skid buffer: ready ripples back combinationally from out_ready.
  assign w_s2_adv  = (r_s2_st == EMPTY) || out_ready;
  assign w_s1_adv  = (r_s1_st == EMPTY) || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = (r_s2_st == FULL);
  assign result    = r_result;

  // Next occupancy of each pipeline register.
  always_comb begin
    w_s1_nxt = r_s1_st;
    w_s2_nxt = r_s2_st;
    if (w_s1_adv) begin
      w_s1_nxt = in_valid ? FULL : EMPTY;
    end
    if (w_s2_adv) begin
      w_s2_nxt = r_s1_st;
    end
  end

  // Occupancy registers; reset drops all in-flight requests.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_st <= EMPTY;
      r_s2_st <= EMPTY;
    end else begin
      r_s1_st <= w_s1_nxt;
      r_s2_st <= w_s2_nxt;
    end
  end

  // S1 data capture on accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_data  <= '0;
      r_s1_shamt <= '0;
      r_s1_op    <= SHIFT_OP_SLL;
      r_s1_fill  <= 1'b0;
    end else if (w_s1_adv && in_valid) begin
      r_s1_data  <= w_d4;
      r_s1_shamt <= shamt[1:0];
      r_s1_op    <= op;
      r_s1_fill  <= w_s1_fill;
    end
  end

  // S2 result capture when S1 hands a request forward.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result <= '0;
    end else if (w_s2_adv && (r_s1_st == FULL)) begin
      r_result <= w_s2_res;
    end
  end

endmodule
